// File: rtl/tx_arb_pkg.sv
// tx_arb_pkg: shared types and constants for the tx_arbiter slice.
// State encoding, owner constants, default row-word width and the
// round-robin pick helper used in IDLE.
package tx_arb_pkg;

    localparam int DEFAULT_DATA_W = 64;

    localparam logic OWNER_A = 1'b0;
    localparam logic OWNER_B = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_SEND = 3'd1,
        ST_WAIT = 3'd2,
        ST_ACK  = 3'd3,
        ST_HOLD = 3'd4
    } arb_state_t;

    // Pick the requester to grant from IDLE: a lone requester wins,
    // a tie goes to the requester that did not own the previous frame.
    function automatic logic rr_pick(input logic req_a, input logic req_b,
                                     input logic last_owner);
        logic pick;
        if (req_a && req_b) begin
            pick = ~last_owner;
        end else if (req_b) begin
            pick = OWNER_B;
        end else begin
            pick = OWNER_A;
        end
        return pick;
    endfunction

endpackage

// File: rtl/tx_arb_watchdog.sv
// tx_arb_watchdog: WAIT-state watchdog for tx_arbiter.
// Only compiled when TX_ARB_WATCHDOG_EN is defined. Counts cycles while
// enabled, restarts on clear, raises a one-cycle expire once the count
// reaches TIMEOUT_CYC and keeps a sticky error flag until rst_n.
`ifdef TX_ARB_WATCHDOG_EN
module tx_arb_watchdog #(
    parameter int TIMEOUT_CYC = 2_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enable,
    input  logic clear,
    output logic expire,
    output logic err
);

    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYC);

    logic [CNT_W-1:0] count_r;

    // Cycle counter: restarts on WAIT entry, saturates at the limit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= {CNT_W{1'b0}};
        end else if (clear) begin
            count_r <= {CNT_W{1'b0}};
        end else if (enable && (count_r != LIMIT)) begin
            count_r <= count_r + CNT_W'(1);
        end
    end

    assign expire = enable && (count_r == LIMIT);

    // Sticky error flag: set on the first expiry, cleared only by rst_n.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err <= 1'b0;
        end else if (expire) begin
            err <= 1'b1;
        end
    end

endmodule
`endif

// File: rtl/tx_arbiter.sv
// tx_arbiter: frame-atomic round-robin arbiter sharing one LED transmitter
// between the animation path (A) and the need-bar overlay (B).
// Ownership is kept for a whole frame so rows never interleave on the chain.
// Optional WAIT watchdog: define TX_ARB_WATCHDOG_EN.
module tx_arbiter
    import tx_arb_pkg::*;
#(
    parameter int DATA_W      = DEFAULT_DATA_W,
    parameter int TIMEOUT_CYC = 2_000_000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              a_req,
    input  logic              a_last,
    input  logic [DATA_W-1:0] a_data,
    output logic              a_ack,
    input  logic              b_req,
    input  logic              b_last,
    input  logic [DATA_W-1:0] b_data,
    output logic              b_ack,
    output logic              tx_send,
    output logic [DATA_W-1:0] tx_data,
    input  logic              tx_done,
    output logic              owner,
    output logic              busy,
    output logic              timeout_err
);

    arb_state_t        state_r;
    arb_state_t        next_state_s;
    logic              rr_last_r;
    logic              last_q_r;
    logic              grant_s;
    logic              grant_owner_s;
    logic              timeout_hit_s;
    logic              owner_req_s;
    logic [DATA_W-1:0] grant_data_s;
    logic              grant_last_s;
    logic              wd_expire_s;

`ifdef TX_ARB_WATCHDOG_EN
    logic wd_enable_s;
    logic wd_clear_s;

    assign wd_enable_s = (state_r == ST_WAIT);
    // SEND always leads to WAIT, so clearing in SEND restarts the count on entry.
    assign wd_clear_s  = (state_r == ST_SEND);

    tx_arb_watchdog #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_watchdog (
        .clk   (clk),
        .rst_n (rst_n),
        .enable(wd_enable_s),
        .clear (wd_clear_s),
        .expire(wd_expire_s),
        .err   (timeout_err)
    );
`else
    // No watchdog: WAIT holds until tx_done. The limit is never reachable here.
    assign wd_expire_s = (TIMEOUT_CYC < 0) ? 1'b1 : 1'b0;
    assign timeout_err = 1'b0;
`endif

    // Request line of the current frame owner, used to continue a frame in HOLD.
    always_comb begin
        owner_req_s = 1'b0;
        if (owner == OWNER_B) begin
            owner_req_s = b_req;
        end else begin
            owner_req_s = a_req;
        end
    end

    // Next-state logic and grant decision.
    always_comb begin
        next_state_s  = state_r;
        grant_s       = 1'b0;
        grant_owner_s = owner;
        timeout_hit_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (a_req || b_req) begin
                    grant_s       = 1'b1;
                    grant_owner_s = rr_pick(a_req, b_req, rr_last_r);
                    next_state_s  = ST_SEND;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_SEND: begin
                next_state_s = ST_WAIT;
            end
            ST_WAIT: begin
                if (tx_done) begin
                    next_state_s = ST_ACK;
                end else if (wd_expire_s) begin
                    next_state_s  = ST_ACK;
                    timeout_hit_s = 1'b1;
                end else begin
                    next_state_s = ST_WAIT;
                end
            end
            ST_ACK: begin
                if (last_q_r) begin
                    next_state_s = ST_IDLE;
                end else begin
                    next_state_s = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (owner_req_s) begin
                    grant_s      = 1'b1;
                    next_state_s = ST_SEND;
                end else begin
                    next_state_s = ST_HOLD;
                end
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // Word and last flag presented by whichever requester is being granted.
    always_comb begin
        grant_data_s = a_data;
        grant_last_s = a_last;
        if (grant_owner_s == OWNER_B) begin
            grant_data_s = b_data;
            grant_last_s = b_last;
        end else begin
            grant_data_s = a_data;
            grant_last_s = a_last;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Registered outputs and the latched word; strobes follow the state being entered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_send  <= 1'b0;
            a_ack    <= 1'b0;
            b_ack    <= 1'b0;
            busy     <= 1'b0;
            owner    <= OWNER_A;
            tx_data  <= {DATA_W{1'b0}};
            last_q_r <= 1'b0;
        end else begin
            tx_send <= (next_state_s == ST_SEND);
            busy    <= (next_state_s != ST_IDLE);
            a_ack   <= (next_state_s == ST_ACK) && (owner == OWNER_A);
            b_ack   <= (next_state_s == ST_ACK) && (owner == OWNER_B);
            if (grant_s) begin
                tx_data  <= grant_data_s;
                last_q_r <= grant_last_s;
                owner    <= grant_owner_s;
            end else if (timeout_hit_s) begin
                // A timed-out word ends the frame so the other source is not starved.
                last_q_r <= 1'b1;
            end
        end
    end

    // Round-robin memory: remember who owned the frame that just completed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_last_r <= OWNER_B;
        end else if ((state_r == ST_ACK) && last_q_r) begin
            rr_last_r <= owner;
        end
    end

endmodule

// File: doc/tx_arbiter.md
# tx_arbiter

Frame-atomic round-robin arbiter that shares the single serial LED transmitter between two word sources: the animation image path (requester A) and the need-bar status overlay (requester B). It sits between the two image generators and the transmitter. It latches one 64-bit row word at a time, issues a one-cycle send strobe, waits for the transmitter's done pulse, and acknowledges the owning requester. Ownership is held for a whole frame so rows from different sources never interleave on the LED chain.

## Interface
- DATA_W, 64, width of one row word
- TIMEOUT_CYC, 2_000_000, cycles allowed in WAIT before the watchdog fires; used only with the watchdog compiled in
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- a_req  in  1  requester A has a word on a_data
- a_last  in  1  the word on a_data is the last of A's frame
- a_data  in  DATA_W  row word from A
- a_ack  out  1  one-cycle pulse: A's word has been transmitted
- b_req, b_last, b_data, b_ack  same as the A ports, for requester B
- tx_send  out  1  one-cycle strobe to the transmitter
- tx_data  out  DATA_W  registered word; stable from the strobe until done
- tx_done  in  1  one-cycle pulse from the transmitter at end of word
- owner  out  1  current or last owner; 0 = A, 1 = B
- busy  out  1  high in any state other than IDLE
- timeout_err  out  1  sticky watchdog flag

## Operation
- States: IDLE, SEND, WAIT, ACK, HOLD.
- IDLE: if exactly one req is high, grant that requester. If both are high, grant the requester not pointed to by rr_last; rr_last resets to B, so A wins the first tie. On grant, latch data and last into tx_data and a last_q register, then go to SEND.
- SEND: tx_send=1 for exactly one cycle, then go to WAIT.
- WAIT: hold until tx_done=1, then go to ACK. A tx_done pulse in any other state is ignored.
- ACK: pulse the owner's ack for one cycle. If last_q=1, set rr_last to owner and go to IDLE. Otherwise go to HOLD.
- HOLD: wait for the owner's req. On req, latch the owner's word and go to SEND. The other requester is blocked regardless of its req.
- Requester obligations:
  - Keep req, data and last stable until ack.
  - req during the ack cycle is treated as stale and ignored. The next word is sampled no earlier than the cycle after ack.
- Reset values:
  - a_ack, b_ack, tx_send, busy, timeout_err are 0.
  - tx_data is 0 and owner is 0.
  - State is IDLE and rr_last is B.
- rst_n asserted mid-frame: immediate return to IDLE. No ack is issued and the partial frame is abandoned. Requesters restart their frame from row 0.

## Timing
- req high at edge k in IDLE or HOLD: tx_data valid and tx_send=1 during cycle k+1.
- tx_done sampled at edge m: ack high during cycle m+1.
- Minimum word turnaround is ack + 1 cycle before the next grant sample.
- busy rises with tx_send and falls in the cycle after the final ack of a frame.
- Nothing combinational from any input to any output; all outputs are registered.

## Configuration
- TX_ARB_WATCHDOG_EN defined:
  - A counter runs in WAIT.
  - If it reaches TIMEOUT_CYC without tx_done, timeout_err is set (sticky until rst_n) and ACK is forced to the owner.
  - The frame is then treated as ended (last_q forced to 1) and the arbiter returns to IDLE.
  - The counter clears on every entry to WAIT.
- Not defined: WAIT holds indefinitely, the counter is not instantiated, and timeout_err is tied to 0.

## Structure
- Package tx_arb_pkg holds:
  - the state encoding (IDLE, SEND, WAIT, ACK, HOLD)
  - owner constants OWNER_A=0 and OWNER_B=1
  - the default DATA_W
- Sub-module tx_arb_watchdog:
  - contains the counter, compare and sticky flag
  - inputs: clk, rst_n, enable (in WAIT), clear (on WAIT entry)
  - output: expire pulse
  - instantiated only under TX_ARB_WATCHDOG_EN

## Test plan
- A-only 8-row frame, tx_done 20 cycles after each tx_send: 8 tx_send strobes with tx_data equal to A's words in order; 8 a_ack pulses; b_ack stays 0; busy=0 two cycles after the 8th ack.
- Both req high in IDLE after reset: A is granted first. After A's frame ends (last=1), B is granted; B's first tx_send comes 2 cycles after A's final ack.
- B asserts req during A's 4-row frame: no B word appears until A's row with last=1 is acked; tx_data never mixes A and B words within a frame.
- Spurious tx_done in IDLE and HOLD, plus req held through the ack cycle: no state change; exactly one tx_send per requested word.
- rst_n pulsed low while in WAIT: all outputs return to reset values asynchronously; the next A req produces tx_send one cycle after sampling.
- With TX_ARB_WATCHDOG_EN and TIMEOUT_CYC=100, tx_done never arrives: a_ack pulses at WAIT entry + 101 cycles, timeout_err=1 and stays set, state returns to IDLE. Without the macro: still in WAIT after 10000 cycles and timeout_err=0.
